// File: rtl/fifo_flags.sv
// rtl/fifo_flags.sv - synchronous FIFO with occupancy count, threshold flags, sticky errors, FWFT option
//
// Purpose: single-clock FIFO where every entry is usable. Occupancy is tracked
// in a dedicated count register, and all status flags are decoded from it.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   synchronous active-low reset
//   write_en     in   write request
//   data_in      in   write data
//   read_en      in   read request (FWFT: pop head)
//   data_out     out  read data (registered, or head word in FWFT mode)
//   data_valid   out  standard: data_out updated this cycle; FWFT: head present
//   empty        out  count == 0
//   full         out  count == FIFO_DEPTH
//   almost_empty out  count <= AEMPTY_THRESH
//   almost_full  out  count >= AFULL_THRESH
//   count        out  current occupancy 0..FIFO_DEPTH
//   overflow     out  sticky: a write was rejected
//   underflow    out  sticky: a read was rejected
module fifo_flags #(
    parameter int FIFO_DEPTH    = 16,
    parameter int FIFO_WIDTH    = 8,
    parameter int AFULL_THRESH  = 12,
    parameter int AEMPTY_THRESH = 4,
    parameter int FWFT          = 0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          write_en,
    input  logic [FIFO_WIDTH-1:0]         data_in,
    input  logic                          read_en,
    output logic [FIFO_WIDTH-1:0]         data_out,
    output logic                          data_valid,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_empty,
    output logic                          almost_full,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [FIFO_WIDTH-1:0] r_mem [0:FIFO_DEPTH-1];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_empty;
    logic                  w_full;
    logic                  w_read_ok;
    logic                  w_write_ok;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(FIFO_DEPTH));
    assign w_read_ok  = read_en & ~w_empty;
    // A write into a full FIFO is still accepted when a read frees a slot in the same cycle.
    assign w_write_ok = write_en & (~w_full | w_read_ok);

    assign empty        = w_empty;
    assign full         = w_full;
    assign almost_empty = (r_count <= CW'(AEMPTY_THRESH));
    assign almost_full  = (r_count >= CW'(AFULL_THRESH));
    assign count        = r_count;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

    // Storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (w_write_ok) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_write_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_read_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_write_ok, w_read_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (write_en && !w_write_ok) begin
                r_overflow <= 1'b1;
            end
            if (read_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Head word is presented combinationally; zero when nothing is stored.
            assign data_out   = w_empty ? '0 : r_mem[r_rd_ptr];
            assign data_valid = ~w_empty;
        end else begin : g_std
            logic [FIFO_WIDTH-1:0] r_data_out;
            logic                  r_data_valid;

            always_ff @(posedge clk) begin
                if (!reset) begin
                    r_data_out   <= '0;
                    r_data_valid <= 1'b0;
                end else if (w_read_ok) begin
                    r_data_out   <= r_mem[r_rd_ptr];
                    r_data_valid <= 1'b1;
                end else begin
                    r_data_valid <= 1'b0;
                end
            end

            assign data_out   = r_data_out;
            assign data_valid = r_data_valid;
        end
    endgenerate

endmodule

// File: tb/tb_fifo_flags.sv
// tb/tb_fifo_flags.sv - randomized + directed bench for fifo_flags (standard and FWFT instances)
module tb_fifo_flags;

    localparam int DEPTH = 16;
    localparam int WIDTH = 8;
    localparam int AFULL = 12;
    localparam int AEMPTY = 4;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             write_en = 1'b0;
    logic             read_en = 1'b0;
    logic [WIDTH-1:0] data_in = '0;

    logic [WIDTH-1:0] s_data_out, f_data_out;
    logic             s_data_valid, f_data_valid;
    logic             s_empty, s_full, s_aempty, s_afull, s_ovf, s_unf;
    logic             f_empty, f_full, f_aempty, f_afull, f_ovf, f_unf;
    logic [4:0]       s_count, f_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a queue of stored words plus sticky bits and the standard-mode output register.
    logic [WIDTH-1:0] m_q[$];
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;
    logic [WIDTH-1:0] m_dout = '0;
    logic             m_dv = 1'b0;

    always #5 clk = ~clk;

    fifo_flags #(
        .FIFO_DEPTH(DEPTH), .FIFO_WIDTH(WIDTH), .AFULL_THRESH(AFULL),
        .AEMPTY_THRESH(AEMPTY), .FWFT(0)
    ) u_std (
        .clk(clk), .reset(reset), .write_en(write_en), .data_in(data_in),
        .read_en(read_en), .data_out(s_data_out), .data_valid(s_data_valid),
        .empty(s_empty), .full(s_full), .almost_empty(s_aempty),
        .almost_full(s_afull), .count(s_count), .overflow(s_ovf), .underflow(s_unf)
    );

    fifo_flags #(
        .FIFO_DEPTH(DEPTH), .FIFO_WIDTH(WIDTH), .AFULL_THRESH(AFULL),
        .AEMPTY_THRESH(AEMPTY), .FWFT(1)
    ) u_fwft (
        .clk(clk), .reset(reset), .write_en(write_en), .data_in(data_in),
        .read_en(read_en), .data_out(f_data_out), .data_valid(f_data_valid),
        .empty(f_empty), .full(f_full), .almost_empty(f_aempty),
        .almost_full(f_afull), .count(f_count), .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input logic we, input logic re, input logic [WIDTH-1:0] din,
                              input logic rst_n);
        int  sz;
        bit  rd_ok, wr_ok;
        if (!rst_n) begin
            m_q.delete();
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_dout = '0;
            m_dv   = 1'b0;
            return;
        end
        sz    = m_q.size();
        rd_ok = re && (sz > 0);
        wr_ok = we && ((sz < DEPTH) || rd_ok);
        if (we && !wr_ok) m_ovf = 1'b1;
        if (re && sz == 0) m_unf = 1'b1;
        if (rd_ok) begin
            m_dout = m_q.pop_front();
            m_dv   = 1'b1;
        end else begin
            m_dv = 1'b0;
        end
        if (wr_ok) m_q.push_back(din);
    endtask

    task automatic check_all();
        int sz;
        sz = m_q.size();
        chk("std_count",  32'(s_count),  32'(sz));
        chk("std_empty",  32'(s_empty),  32'(sz == 0));
        chk("std_full",   32'(s_full),   32'(sz == DEPTH));
        chk("std_aempty", 32'(s_aempty), 32'(sz <= AEMPTY));
        chk("std_afull",  32'(s_afull),  32'(sz >= AFULL));
        chk("std_ovf",    32'(s_ovf),    32'(m_ovf));
        chk("std_unf",    32'(s_unf),    32'(m_unf));
        chk("std_dv",     32'(s_data_valid), 32'(m_dv));
        chk("std_dout",   32'(s_data_out),   32'(m_dout));
        chk("fwft_count", 32'(f_count),  32'(sz));
        chk("fwft_ovf",   32'(f_ovf),    32'(m_ovf));
        chk("fwft_unf",   32'(f_unf),    32'(m_unf));
        chk("fwft_dv",    32'(f_data_valid), 32'(sz > 0));
        chk("fwft_dout",  32'(f_data_out),   (sz > 0) ? 32'(m_q[0]) : 32'h0);
    endtask

    task automatic step(input logic we, input logic re, input logic [WIDTH-1:0] din,
                        input logic rst_n);
        write_en = we;
        read_en  = re;
        data_in  = din;
        reset    = rst_n;
        @(posedge clk);
        model_edge(we, re, din, rst_n);
        #1;
        check_all();
    endtask

    initial begin
        int wp, rp;
        logic [WIDTH-1:0] v;

        // Reset state
        step(1'b0, 1'b0, 8'h00, 1'b0);
        chk("rst_empty", 32'(s_empty), 32'd1);
        chk("rst_aempty", 32'(s_aempty), 32'd1);
        chk("rst_dout", 32'(s_data_out), 32'd0);

        // Fill with 0x01..0x10
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 8'(i), 1'b1);
        chk("fill_count", 32'(s_count), 32'd16);
        chk("fill_full", 32'(s_full), 32'd1);
        // Overflow attempt
        step(1'b1, 1'b0, 8'hFF, 1'b1);
        chk("ovf_set", 32'(s_ovf), 32'd1);
        chk("ovf_count", 32'(s_count), 32'd16);

        // Simultaneous read/write at full for 5 cycles
        step(1'b0, 1'b0, 8'h00, 1'b0);
        for (int i = 1; i <= DEPTH; i++) step(1'b1, 1'b0, 8'(i), 1'b1);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 8'(8'h80 + i), 1'b1);
        chk("rw_full_count", 32'(s_count), 32'd16);
        chk("rw_full_ovf", 32'(s_ovf), 32'd0);
        chk("rw_full_last", 32'(s_data_out), 32'h05);

        // Drain
        for (int i = 0; i < DEPTH; i++) step(1'b0, 1'b1, 8'h00, 1'b1);
        chk("drain_last", 32'(s_data_out), 32'h84);
        chk("drain_empty", 32'(s_empty), 32'd1);

        // Underflow at empty
        step(1'b0, 1'b1, 8'h00, 1'b1);
        chk("unf_set", 32'(s_unf), 32'd1);
        chk("unf_dv", 32'(s_data_valid), 32'd0);
        chk("unf_dout_hold", 32'(s_data_out), 32'h84);

        // Write at empty with read_en
        step(1'b1, 1'b1, 8'hA5, 1'b1);
        chk("we_re_empty_count", 32'(s_count), 32'd1);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        chk("we_re_empty_data", 32'(s_data_out), 32'hA5);

        // FWFT fall-through
        step(1'b1, 1'b0, 8'h3C, 1'b1);
        chk("fwft_head", 32'(f_data_out), 32'h3C);
        chk("fwft_head_dv", 32'(f_data_valid), 32'd1);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        chk("fwft_pop_dout", 32'(f_data_out), 32'h00);
        chk("fwft_pop_dv", 32'(f_data_valid), 32'd0);

        // Fill to 9 then reset with write_en/read_en high
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'(8'h40 + i), 1'b1);
        chk("pre_rst_count", 32'(s_count), 32'd9);
        step(1'b1, 1'b1, 8'hEE, 1'b0);
        chk("mid_rst_count", 32'(s_count), 32'd0);
        chk("mid_rst_unf", 32'(s_unf), 32'd0);
        chk("mid_rst_dv", 32'(f_data_valid), 32'd0);
        step(1'b1, 1'b0, 8'h5A, 1'b1);
        step(1'b0, 1'b1, 8'h00, 1'b1);
        chk("rt_5a", 32'(s_data_out), 32'h5A);

        // Randomized phases with varying write/read pressure
        for (int ph = 0; ph < 16; ph++) begin
            wp = $urandom_range(10, 90);
            rp = $urandom_range(10, 90);
            for (int c = 0; c < 200; c++) begin
                v = 8'($urandom);
                step(($urandom_range(0, 99) < wp) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 99) < rp) ? 1'b1 : 1'b0,
                     v,
                     ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
